idex_hazard_ctrl: RTL and testbench



---
 rtl/hazard_pkg.sv | 14 +
 rtl/hazard_cnt.sv | 26 ++
 rtl/idex_hazard_ctrl.sv | 138 +++++++++++++
 tb/tb_idex_hazard_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID/EX hazard controller.
// Used by hazard_cnt and idex_hazard_ctrl.
package hazard_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      STALL = 2'd1,
      FLUSH = 2'd2
   } hzState_t;

   localparam logic [4:0]  REG_ZERO = 5'd0;
   localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

endpackage

// File: rtl/hazard_cnt.sv
// Loadable down-counter with an is-one flag; sequences stall/flush length.
// Load wins over decrement; decrement saturates at zero.
module hazard_cnt #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] loadVal,
   input  logic         dec,
   output logic [W-1:0] cnt,
   output logic         isOne
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (load)
         cnt <= loadVal;
      else if (dec && cnt != '0)
         cnt <= cnt - 1'b1;
   end

   assign isOne = (cnt == W'(1));

endmodule

// File: rtl/idex_hazard_ctrl.sv
// ID/EX load-use stall and control-hazard flush sequencer.
// Define HAZARD_PERF_EN to add stall_cycles/flush_cycles counters.
module idex_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int LOAD_USE_CYCLES = 1,
   parameter int FLUSH_SLOTS     = 2,
   parameter int CNT_W           = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_uses_rt,
   input  logic        ex_mem_read,
   input  logic [4:0]  ex_rt,
   input  logic        ex_jump,
   input  logic        ex_branch_taken,
   output logic        pc_write,
   output logic        ifid_write,
   output logic        idex_bubble,
   output logic        ifid_flush,
`ifdef HAZARD_PERF_EN
   output logic [15:0] stall_cycles,
   output logic [15:0] flush_cycles,
`endif
   output logic        busy
);

   localparam logic [CNT_W-1:0] STALL_LOAD = CNT_W'(LOAD_USE_CYCLES - 1);
   localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_SLOTS - 1);

   hzState_t         state;
   logic             lu, ctl;
   logic             cntLoad, cntDec, cntIsOne;
   logic [CNT_W-1:0] cntLoadVal, cnt;

   assign lu = ex_mem_read && (ex_rt != REG_ZERO) &&
               ((ex_rt == id_rs) || (id_uses_rt && ex_rt == id_rt));
   assign ctl = ex_jump || ex_branch_taken;

   always_comb begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      idex_bubble = 1'b0;
      ifid_flush  = 1'b0;
      cntLoad     = 1'b0;
      cntLoadVal  = '0;
      cntDec      = 1'b0;
      unique case (state)
         RUN: begin
            if (ctl) begin
               ifid_flush  = 1'b1;
               idex_bubble = 1'b1;
               cntLoad     = (FLUSH_SLOTS > 1);
               cntLoadVal  = FLUSH_LOAD;
            end else if (lu) begin
               pc_write    = 1'b0;
               ifid_write  = 1'b0;
               idex_bubble = 1'b1;
               cntLoad     = (LOAD_USE_CYCLES > 1);
               cntLoadVal  = STALL_LOAD;
            end
         end
         STALL: begin
            idex_bubble = 1'b1;
            if (ctl) begin
               ifid_flush = 1'b1;
               cntLoad    = 1'b1;
               cntLoadVal = FLUSH_LOAD;
            end else begin
               pc_write   = 1'b0;
               ifid_write = 1'b0;
               cntDec     = 1'b1;
            end
         end
         FLUSH: begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            cntDec      = 1'b1;
         end
         default: ;
      endcase
   end

   assign busy = (state != RUN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RUN;
      end else begin
         unique case (state)
            RUN: begin
               if (ctl && FLUSH_SLOTS > 1)
                  state <= FLUSH;
               else if (!ctl && lu && LOAD_USE_CYCLES > 1)
                  state <= STALL;
            end
            STALL: begin
               if (ctl)
                  state <= (FLUSH_SLOTS > 1) ? FLUSH : RUN;
               else if (cntIsOne)
                  state <= RUN;
            end
            FLUSH: begin
               if (cntIsOne)
                  state <= RUN;
            end
            default: state <= RUN;
         endcase
      end
   end

   hazard_cnt #(.W(CNT_W)) uCnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (cntLoad),
      .loadVal (cntLoadVal),
      .dec     (cntDec),
      .cnt     (cnt),
      .isOne   (cntIsOne)
   );

`ifdef HAZARD_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= '0;
         flush_cycles <= '0;
      end else begin
         if (!pc_write && stall_cycles != 16'hFFFF)
            stall_cycles <= stall_cycles + 16'd1;
         if (ifid_flush && flush_cycles != 16'hFFFF)
            flush_cycles <= flush_cycles + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_idex_hazard_ctrl.sv
// Scoreboard bench: two controllers (LOAD_USE_CYCLES 1 and 3) share stimulus.
// Expected {pc_write,ifid_write,idex_bubble,ifid_flush,busy} queued per cycle.
module tb_idex_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
   logic       id_uses_rt = 1'b0, ex_mem_read = 1'b0;
   logic       ex_jump = 1'b0, ex_branch_taken = 1'b0;

   logic pwA, iwA, bbA, flA, bsA;
   logic pwB, iwB, bbB, flB, bsB;
`ifdef HAZARD_PERF_EN
   logic [15:0] scA, fcA, scB, fcB;
`endif

   int tests = 0;
   int fails = 0;

   typedef struct {
      int         idx;
      logic [4:0] expA;
      logic [4:0] expB;
   } exp_t;

   exp_t q[$];

   always #5 clk = ~clk;

   idex_hazard_ctrl #(.LOAD_USE_CYCLES(1), .FLUSH_SLOTS(2), .CNT_W(3)) dutA (
      .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
      .ex_jump(ex_jump), .ex_branch_taken(ex_branch_taken),
      .pc_write(pwA), .ifid_write(iwA), .idex_bubble(bbA),
      .ifid_flush(flA),
`ifdef HAZARD_PERF_EN
      .stall_cycles(scA), .flush_cycles(fcA),
`endif
      .busy(bsA)
   );

   idex_hazard_ctrl #(.LOAD_USE_CYCLES(3), .FLUSH_SLOTS(2), .CNT_W(3)) dutB (
      .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
      .ex_jump(ex_jump), .ex_branch_taken(ex_branch_taken),
      .pc_write(pwB), .ifid_write(iwB), .idex_bubble(bbB),
      .ifid_flush(flB),
`ifdef HAZARD_PERF_EN
      .stall_cycles(scB), .flush_cycles(fcB),
`endif
      .busy(bsB)
   );

   localparam logic [4:0] IDLE = 5'b11000;
   localparam logic [4:0] LU   = 5'b00100;
   localparam logic [4:0] STL  = 5'b00101;
   localparam logic [4:0] CTL  = 5'b11110;
   localparam logic [4:0] FLS  = 5'b11111;

   int vecIdx = 0;

   task automatic step(input logic rst, input logic [4:0] rs,
                       input logic [4:0] rt, input logic usesRt,
                       input logic memRd, input logic [4:0] exRt,
                       input logic jmp, input logic br,
                       input logic [4:0] eA, input logic [4:0] eB);
      exp_t e;
      @(posedge clk);
      #1;
      rst_n = rst;
      id_rs = rs;
      id_rt = rt;
      id_uses_rt = usesRt;
      ex_mem_read = memRd;
      ex_rt = exRt;
      ex_jump = jmp;
      ex_branch_taken = br;
      e.idx = vecIdx;
      e.expA = eA;
      e.expB = eB;
      q.push_back(e);
      vecIdx++;
   endtask

   task automatic idle(input logic [4:0] eA, input logic [4:0] eB);
      step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, eA, eB);
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         logic [4:0] gotA, gotB;
         e = q.pop_front();
         gotA = {pwA, iwA, bbA, flA, bsA};
         gotB = {pwB, iwB, bbB, flB, bsB};
         tests++;
         if (gotA !== e.expA) begin
            fails++;
            $display("FAIL vec%0d dutA got=%b want=%b", e.idx, gotA, e.expA);
         end
         tests++;
         if (gotB !== e.expB) begin
            fails++;
            $display("FAIL vec%0d dutB got=%b want=%b", e.idx, gotB, e.expB);
         end
`ifdef HAZARD_PERF_EN
         if (e.idx == 17) begin
            tests++;
            if ({scA, fcA, scB, fcB} !== {16'd2, 16'd4, 16'd6, 16'd4}) begin
               fails++;
               $display("FAIL perf vec17 got=%0d/%0d/%0d/%0d want=2/4/6/4",
                        scA, fcA, scB, fcB);
            end
         end
         if (e.idx == 24) begin
            tests++;
            if ({scA, fcA, scB, fcB} !== 64'd0) begin
               fails++;
               $display("FAIL perf reset got=%0d/%0d/%0d/%0d want=0",
                        scA, fcA, scB, fcB);
            end
         end
`endif
      end
   end

   initial begin
      // 0: reset held
      step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, IDLE, IDLE);
      idle(IDLE, IDLE);
      // 2: lw $t0 then add using $t0 as rs
      step(1'b1, 5'd8, 5'd9, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, LU, LU);
      idle(IDLE, STL);
      idle(IDLE, STL);
      idle(IDLE, IDLE);
      // 6: $0 never hazards
      step(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, IDLE, IDLE);
      // 7: sw reading rt
      step(1'b1, 5'd3, 5'd8, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, LU, LU);
      idle(IDLE, STL);
      idle(IDLE, STL);
      idle(IDLE, IDLE);
      // 11: rt matches but is not read
      step(1'b1, 5'd3, 5'd8, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, IDLE, IDLE);
      // 12: taken branch
      step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, CTL, CTL);
      idle(FLS, FLS);
      idle(IDLE, IDLE);
      // 15: load-use and jump together, flush wins
      step(1'b1, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, CTL, CTL);
      idle(FLS, FLS);
      idle(IDLE, IDLE);
      // 18: stall, then jump aborts it in dutB
      step(1'b1, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, LU, LU);
      step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, CTL, FLS);
      idle(FLS, FLS);
      idle(IDLE, IDLE);
      // 22: branch, then reset mid-flush
      step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, CTL, CTL);
      step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, IDLE, IDLE);
      idle(IDLE, IDLE);
      repeat (3) @(posedge clk);
      tests++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL drain left=%0d want=0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
